fcmp_pipe: RTL
==============

FCMP_PIPE -- requirements
Module: fcmp_pipe

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 23, mantissa field width; operand width W = 1+EXP_W+MAN_W.
REQ-003 SHALL have parameter TAG_W, default 4, width of the opaque tag passed through with each operation.
REQ-004 SHALL have port clk, input, 1, sole clock; all state updates on its rising edge.
REQ-005 SHALL have port rstn, input, 1; reset is synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, operation offered.
REQ-007 SHALL have port in_ready, output, 1, operation accepted when in_valid & in_ready at clock edge.
REQ-008 SHALL have port srca, input, W, operand A {sign, exponent, mantissa}.
REQ-009 SHALL have port srcb, input, W, operand B.
REQ-010 SHALL have port mode, input, 2, 00=LT (A<B), 01=LE (A<=B), 10=EQ (A==B), 11=reserved.
REQ-011 SHALL have port in_tag, input, TAG_W, carried unchanged to out_tag.
REQ-012 SHALL have port out_valid, output, 1, result available.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result when out_valid & out_ready.
REQ-014 SHALL have port result, output, 1, comparison outcome.
REQ-015 SHALL have port out_tag, output, TAG_W, tag of the operation on result.

Function
REQ-016 SHALL treat any operand with exponent field all-zero as zero regardless of sign and mantissa (denormals flushed; +0 == -0).
REQ-017 SHALL apply no special NaN/Inf handling: exponent all-ones operands compare as ordinary sign-magnitude values.
REQ-018 SHALL compute LT: both zero -> 0; A zero only -> ~sign(B); B zero only -> sign(A); signs differ -> sign(A); both positive -> mag(A)<mag(B); both negative -> mag(A)>mag(B), where mag = bits [W-2:0].
REQ-019 SHALL compute EQ: both zero -> 1; exactly one zero -> 0; otherwise all W bits equal.
REQ-020 SHALL compute LE as LT | EQ; mode 11 SHALL produce result 0 with normal handshake.
REQ-021 SHALL be a two-stage pipeline: stage 1 registers zero flags, signs, magnitude-less and magnitude-equal, mode, tag; stage 2 registers result and tag.
REQ-022 SHALL have latency exactly 2 cycles from accept to out_valid when out_ready is held high.
REQ-023 SHALL sustain throughput of one operation per cycle when out_ready is held high.
REQ-024 SHALL define s2_adv = ~s2_valid | out_ready, s1_adv = ~s1_valid | s2_adv, in_ready = s1_adv (combinational, no bubble required).
REQ-025 SHALL hold result and out_tag stable while out_valid & ~out_ready.
REQ-026 SHALL never drop, duplicate or reorder operations under any out_ready pattern; holds at most 2 in flight.
REQ-027 SHALL, on simultaneous accept and output handshake with both stages full, advance both stages in the same cycle.
REQ-028 SHALL not change stage contents when the stage's advance condition is false.

Reset
REQ-029 SHALL, while rstn=0 at a clock edge, clear s1_valid and s2_valid; out_valid=0, result=0, out_tag=0 after that edge.
REQ-030 SHALL discard in-flight operations on reset mid-operation; in_ready SHALL be 1 in the first cycle after reset release.
REQ-031 SHALL ignore in_valid during reset cycles.

Structure
REQ-032 SHALL place the mode encoding (enum LT/LE/EQ/RSVD) and default EXP_W/MAN_W constants in shared package fpu_pkg.
REQ-033 SHALL implement classification/compare in combinational sub-module fcmp_core (parameters EXP_W, MAN_W; outputs lt, eq), instantiated once in stage 1.

Verification
REQ-034 SHALL cover: LT A=0x3F800000 (1.0), B=0x40000000 (2.0) -> result 1 two cycles after accept; swapped -> 0.
REQ-035 SHALL cover: EQ A=0x00000000, B=0x80000000 -> 1; LT A=0x00000001 (denormal), B=0x80000000 -> 0; LE same -> 1.
REQ-036 SHALL cover: LT A=0xBF800000 (-1.0), B=0xC0000000 (-2.0) -> 0; LT A=0xC0000000, B=0xBF800000 -> 1; mode 11 any -> 0.
REQ-037 SHALL cover: 10 back-to-back ops tags 0..9, out_ready=1 -> in_ready constant 1, results tags 0..9 in order, one per cycle.
REQ-038 SHALL cover: out_ready=0 for 5 cycles during stream -> in_ready falls after 2 accepts, result/out_tag stable, all ops delivered in order afterwards.
REQ-039 SHALL cover: rstn=0 for one cycle with 2 ops in flight -> out_valid=0 next cycle, no stale result emitted, new op completes with 2-cycle latency.

Source files
------------

// File: rtl/fpu_pkg.sv
// Shared definitions for the floating-point compare pipeline: default
// field widths, comparison mode encoding, the operand classification
// record carried between pipeline stages, and the mode-to-result mapping.
package fpu_pkg;

  localparam int DEF_EXP_W = 8;
  localparam int DEF_MAN_W = 23;

  typedef enum logic [1:0] {
    CMP_LT   = 2'b00,
    CMP_LE   = 2'b01,
    CMP_EQ   = 2'b10,
    CMP_RSVD = 2'b11
  } cmp_mode_t;

  // Everything needed to decide LT/EQ once the wide magnitude compare is done.
  typedef struct packed {
    logic a_zero;
    logic b_zero;
    logic a_sign;
    logic b_sign;
    logic mag_lt;
    logic mag_eq;
  } cmp_class_t;

  // Reserved mode yields 0 but still travels through the pipe normally.
  function automatic logic select_result(cmp_mode_t m, logic lt, logic eq);
    logic r;
    r = 1'b0;
    case (m)
      CMP_LT:  r = lt;
      CMP_LE:  r = lt | eq;
      CMP_EQ:  r = eq;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/fcmp_core.sv
// Combinational compare core. The classify half reduces the raw operands
// to zero flags, signs and a magnitude compare; the resolve half turns a
// (registered) classification record into lt/eq. Splitting it this way
// keeps the wide magnitude comparator on its own side of the stage-1 register.
module fcmp_core
  import fpu_pkg::*;
#(
  parameter int  EXP_W = DEF_EXP_W,
  parameter int  MAN_W = DEF_MAN_W,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  cmp_class_t   cls_in,
  output cmp_class_t   cls,
  output logic         lt,
  output logic         eq
);

  // Classify raw operands; a zero exponent flushes the operand to zero.
  always_comb begin : classify
    cls        = '0;
    cls.a_zero = (a[W-2 -: EXP_W] == '0);
    cls.b_zero = (b[W-2 -: EXP_W] == '0);
    cls.a_sign = a[W-1];
    cls.b_sign = b[W-1];
    cls.mag_lt = (a[W-2:0] <  b[W-2:0]);
    cls.mag_eq = (a[W-2:0] == b[W-2:0]);
  end

  // Resolve sign-magnitude ordering and equality from a classification record.
  always_comb begin : resolve
    lt = 1'b0;
    eq = 1'b0;
    if (cls_in.a_zero && cls_in.b_zero) begin
      eq = 1'b1;
    end else if (cls_in.a_zero) begin
      lt = ~cls_in.b_sign;
    end else if (cls_in.b_zero) begin
      lt = cls_in.a_sign;
    end else if (cls_in.a_sign != cls_in.b_sign) begin
      lt = cls_in.a_sign;
    end else begin
      lt = cls_in.a_sign ? (~cls_in.mag_lt & ~cls_in.mag_eq) : cls_in.mag_lt;
      eq = cls_in.mag_eq;
    end
  end

endmodule

// File: rtl/fcmp_pipe.sv
// Two-stage floating-point comparator with valid/ready handshakes on both
// sides. Stage 1 holds the operand classification, mode and tag; stage 2
// holds the final result and tag. Each stage advances when it is empty or
// the stage downstream is moving, so a full pipe streams one op per cycle.
module fcmp_pipe
  import fpu_pkg::*;
#(
  parameter int  EXP_W = DEF_EXP_W,
  parameter int  MAN_W = DEF_MAN_W,
  parameter int  TAG_W = 4,
  localparam int W     = 1 + EXP_W + MAN_W
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [W-1:0]     srca,
  input  logic [W-1:0]     srcb,
  input  logic [1:0]       mode,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             result,
  output logic [TAG_W-1:0] out_tag
);

  logic             s1_valid_reg;
  cmp_class_t       s1_class_reg;
  cmp_mode_t        s1_mode_reg;
  logic [TAG_W-1:0] s1_tag_reg;

  logic             s2_valid_reg;
  logic             s2_result_reg;
  logic [TAG_W-1:0] s2_tag_reg;

  cmp_class_t       class_next;
  logic             lt;
  logic             eq;
  logic             s1_adv;
  logic             s2_adv;

  fcmp_core #(
    .EXP_W (EXP_W),
    .MAN_W (MAN_W)
  ) u_core (
    .a      (srca),
    .b      (srcb),
    .cls_in (s1_class_reg),
    .cls    (class_next),
    .lt     (lt),
    .eq     (eq)
  );

  assign s2_adv    = ~s2_valid_reg | out_ready;
  assign s1_adv    = ~s1_valid_reg | s2_adv;
  assign in_ready  = s1_adv;
  assign out_valid = s2_valid_reg;
  assign result    = s2_result_reg;
  assign out_tag   = s2_tag_reg;

  // Stage 1: capture classification, mode and tag of an accepted op.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s1_valid_reg <= 1'b0;
      s1_class_reg <= '0;
      s1_mode_reg  <= CMP_LT;
      s1_tag_reg   <= '0;
    end else if (s1_adv) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_class_reg <= class_next;
        s1_mode_reg  <= cmp_mode_t'(mode);
        s1_tag_reg   <= in_tag;
      end
    end
  end

  // Stage 2: resolve the comparison and hold it until the consumer takes it.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      s2_valid_reg  <= 1'b0;
      s2_result_reg <= 1'b0;
      s2_tag_reg    <= '0;
    end else if (s2_adv) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_result_reg <= select_result(s1_mode_reg, lt, eq);
        s2_tag_reg    <= s1_tag_reg;
      end
    end
  end

endmodule
